// File: rtl/plane_recip_div_pkg.sv
// -----------------------------------------------------------------------------
// plane_recip_div_pkg
// Shared constants for the VGA-demo perspective ground plane. The constants
// below set the plane reciprocal divider width and latency. They also give
// the lead time the scanline engine allows between the divider start pulse
// and hblank.
// -----------------------------------------------------------------------------
package plane_recip_div_pkg;

    localparam int PLANE_NUMER_LOG2  = 16;  // numerator is 2^PLANE_NUMER_LOG2
    localparam int PLANE_QW          = 11;  // quotient width
    localparam int PLANE_DW          = 10;  // divisor width

    // Clocks from start to recip/done visible
    localparam int PLANE_DIV_LATENCY = PLANE_QW + 1;

    // The scanline engine pulses start this many clocks before the end of
    // active video (H_DISPLAY - PLANE_START_LEAD). It latches recip at hblank.
    localparam int PLANE_START_LEAD  = 16;
    localparam bit PLANE_DIV_FITS    = (PLANE_DIV_LATENCY <= PLANE_START_LEAD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } plane_div_state_t;

endpackage

// File: rtl/plane_recip_div.sv
// -----------------------------------------------------------------------------
// plane_recip_div
// Restoring reciprocal divider. It computes the result for a new request in
// a fixed QW+1 clocks from start, producing one quotient bit per clock:
//     recip = min(floor(2^NUMER_LOG2 / denom), 2^QW - 1)
// A denom of 0 also gives 2^QW - 1.
//
// Ports
//   clk48  : pixel clock
//   rst_n  : asynchronous active-low reset
//   start  : single-cycle request; denom is sampled on the same edge.
//            A start during an operation aborts that operation and restarts.
//   denom  : divisor (plane row index + 1)
//   recip  : last completed quotient, held until the next completion
//   busy   : high while quotient bits are being produced
//   done   : one-cycle pulse on the cycle recip updates
// -----------------------------------------------------------------------------
module plane_recip_div
    import plane_recip_div_pkg::*;
#(
    parameter int NUMER_LOG2 = PLANE_NUMER_LOG2,
    parameter int QW         = PLANE_QW,
    parameter int DW         = PLANE_DW
) (
    input  logic          clk48,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] denom,
    output logic [QW-1:0] recip,
    output logic          busy,
    output logic          done
);

    localparam int CW = $clog2(QW);

    // The top NUMER_LOG2-QW numerator bits are consumed up front. This gives
    // the initial partial remainder. Any divisor at or below it would overflow
    // the QW-bit quotient, so such a divisor saturates.
    localparam logic [DW:0] SAT_LIMIT = {{DW{1'b0}}, 1'b1} << (NUMER_LOG2 - QW);

    plane_div_state_t state, state_n;

    logic [DW-1:0] d_reg, d_n;
    logic [DW:0]   r_reg, r_n;
    logic [QW-1:0] q_reg, q_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          sat, sat_n;
    logic [QW-1:0] recip_n;
    logic          done_n;

    logic [DW:0]   r2;
    logic          ge;

    // Without saturation, R < D < 2^DW, so the shifted remainder fits in
    // DW+1 bits and the top bit dropped here is always zero.
    assign r2 = {r_reg[DW-1:0], 1'b0};
    assign ge = (r2 >= {1'b0, d_reg});

    always_comb begin
        state_n = state;
        d_n     = d_reg;
        r_n     = r_reg;
        q_n     = q_reg;
        cnt_n   = cnt;
        sat_n   = sat;
        recip_n = recip;
        done_n  = 1'b0;

        if (start) begin
            // start takes priority in every state. This also suppresses a
            // FINISH write that coincides with a new request.
            d_n     = denom;
            sat_n   = ({1'b0, denom} <= SAT_LIMIT);
            r_n     = SAT_LIMIT;
            q_n     = '0;
            cnt_n   = CW'(QW - 1);
            state_n = RUN;
        end else begin
            case (state)
                RUN: begin
                    r_n = ge ? (r2 - {1'b0, d_reg}) : r2;
                    q_n = {q_reg[QW-2:0], ge};
                    if (cnt == '0) begin
                        state_n = FINISH;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                FINISH: begin
                    recip_n = sat ? '1 : q_reg;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            d_reg <= '0;
            r_reg <= '0;
            q_reg <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
            recip <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            d_reg <= d_n;
            r_reg <= r_n;
            q_reg <= q_n;
            cnt   <= cnt_n;
            sat   <= sat_n;
            recip <= recip_n;
            done  <= done_n;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: doc/plane_recip_div.md
Name: plane_recip_div

Overview:
Iterative reciprocal divider for the perspective ground plane. It computes the per-line horizontal texture step, floor(2^NUMER_LOG2 / denom), saturated to QW bits, one quotient bit per clock. The scanline engine pulses start during the visible part of a line, 16 clocks before the end of active video, and latches recip at hblank. The result must therefore be ready within 16 clocks of start.

Parameters:
NUMER_LOG2  16  numerator is 2^NUMER_LOG2
QW  11  quotient (recip) width in bits
DW  10  divisor (denom) width in bits

Ports:
clk48  in  1  pixel clock
rst_n  in  1  reset; asynchronous, active-low
start  in  1  single-cycle request; denom is sampled on the same edge
denom  in  DW  divisor (plane row index + 1)
recip  out  QW  last completed quotient; held until the next completion
busy  out  1  high while an iteration is in progress
done  out  1  one-cycle pulse on the cycle recip updates

Behaviour:
- Reset (async assert, sync release): state=IDLE; recip=0; busy=0; done=0; internal remainder, quotient and divisor registers cleared.
- FSM states: IDLE, RUN, FINISH.
- IDLE + start: latch denom into D.
  - If D <= 2^(NUMER_LOG2-QW) (includes D=0), set sat=1.
  - Set R = 2^(NUMER_LOG2-QW), Q=0, cnt=QW-1.
  - Go to RUN. busy=1 from the next cycle.
- RUN, each cycle:
  - R2 = R<<1 (shift in a 0 numerator bit).
  - If R2 >= D: R = R2-D and shift 1 into Q; else R = R2 and shift 0 into Q.
  - After the cycle with cnt==0, go to FINISH; otherwise decrement cnt.
  - R is DW+1 bits wide; compare and subtract at DW+1 bits with no overflow. The invariant R < D holds because sat=0 implies D > 2^(NUMER_LOG2-QW).
- FINISH:
  - recip = sat ? 2^QW-1 : Q.
  - done=1 for exactly this cycle; busy=0.
  - Go to IDLE.
- Latency: with start high at edge 0, recip and done are visible after edge QW+1 (12 for defaults).
  - The requirement is QW+1 <= 15.
- Saturated requests still run the full QW cycles. Latency is constant and never data-dependent.
- start while RUN or FINISH: abort the current operation, re-latch denom, restart at RUN with cnt=QW-1.
  - The aborted result is never written to recip, and no done is issued for it.
  - If start coincides with FINISH, the FINISH write and done pulse are suppressed.
- start held high for several cycles: each cycle restarts. Only the last sample completes.
- recip changes only on FINISH. Between completions it is stable, so the consumer may latch it at any cycle after done.
- rst_n asserted mid-operation: immediate return to IDLE with recip=0. No done is issued.
- Reference values (defaults): denom=34 gives 1927; denom=274 gives 239; denom=33 gives 1985; denom <= 32 gives 2047.

Decomposition:
- Shared package (the team's VGA-demo constants package) holds:
  - PLANE_NUMER_LOG2=16, PLANE_QW=11, PLANE_DW=10.
  - The FSM state enum (IDLE/RUN/FINISH, 2-bit encoding).
  - PLANE_DIV_LATENCY=QW+1.
- The scanline top level takes its start offset (H_DISPLAY-16) from the package and checks it against the latency.
- No sub-module: a single flat module of roughly 120-160 lines.

Test Plan:
- Reset, then start with denom=34 → done exactly 12 cycles after start; recip=1927; busy high for cycles 1-11.
- Back-to-back requests denom=274 then denom=1023, spaced 20 cycles → recip=239 then 64; each with exactly one done pulse.
- Saturation: denom=33 → 1985; denom=32 → 2047; denom=0 → 2047. All three at 12-cycle latency.
- Abort: start denom=100 (→655), then start denom=50 five cycles later → a single done, 12 cycles after the second start; recip=1310; 655 never appears.
- Reset mid-RUN after a prior result of 1927 → recip=0 and busy=0 immediately (asynchronous); no done. A following start with denom=34 completes normally.
- Sweep denom 0..1023 against a golden model min(floor(65536/d), 2047), with d=0 mapped to 2047 → all match; recip stable between done pulses.
